// File: rtl/bomb_pkg.sv
// Shared definitions for the bomb phase sequencer.
//   state_e        : game state encoding (IDLE, ARMED, DEFUSED, EXPLODED)
//   btn_code_t     : 3-bit button code, index of the pressed bit in
//                    {right,left,up,down,a,b} (b=0 ... right=5)
//   SOLUTION       : constant defuse sequence, [phase][step]
//   is_single_press: true when exactly one bit of a 6-bit press vector is set
//   onehot_to_code : maps a single-bit press vector to its button code
//   solution_at    : table lookup used by the sequencer
package bomb_pkg;

  localparam int unsigned SOL_PHASES = 4;
  localparam int unsigned SOL_STEPS  = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_DEFUSED  = 2'd2,
    ST_EXPLODED = 2'd3
  } state_e;

  typedef logic [2:0] btn_code_t;

  localparam btn_code_t SOLUTION [SOL_PHASES][SOL_STEPS] = '{
    '{3'd0, 3'd1, 3'd2, 3'd3},
    '{3'd5, 3'd4, 3'd3, 3'd2},
    '{3'd1, 3'd1, 3'd0, 3'd5},
    '{3'd4, 3'd2, 3'd5, 3'd0}
  };

  // x & (x-1) clears the lowest set bit; zero afterwards means one bit only.
  function automatic logic is_single_press(input logic [5:0] btn);
    return (btn != 6'd0) && ((btn & (btn - 6'd1)) == 6'd0);
  endfunction

  function automatic btn_code_t onehot_to_code(input logic [5:0] btn);
    btn_code_t code;
    case (btn)
      6'b000001: code = 3'd0;
      6'b000010: code = 3'd1;
      6'b000100: code = 3'd2;
      6'b001000: code = 3'd3;
      6'b010000: code = 3'd4;
      6'b100000: code = 3'd5;
      default:   code = 3'd0;
    endcase
    return code;
  endfunction

  function automatic btn_code_t solution_at(input logic [1:0] ph, input logic [1:0] st);
    return SOLUTION[ph][st];
  endfunction

endpackage

// File: rtl/bomb_phase_sequencer_press_arbiter.sv
// press_arbiter: validates the two players' press vectors and picks one.
//   clk, rst   : clock, async active-high reset
//   en_i       : presses are being consumed this cycle (game armed)
//   p1_btn_i   : player-1 press pulses {right,left,up,down,a,b}
//   p2_btn_i   : player-2 press pulses, same order
//   valid_o    : a valid press is offered this cycle (combinational)
//   id_o       : 0 = player 1, 1 = player 2
//   code_o     : button code of the offered press
// On contention the player that did not win last time is chosen; the
// pointer only moves when the press is actually consumed (en_i).
module press_arbiter
  import bomb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [5:0] p1_btn_i,
  input  logic [5:0] p2_btn_i,
  output logic       valid_o,
  output logic       id_o,
  output btn_code_t  code_o
);

  logic p1_ok_s;
  logic p2_ok_s;
  logic rr_q;   // player holding priority on contention: 0 = p1, 1 = p2
  logic rr_d;

  assign p1_ok_s = is_single_press(p1_btn_i);
  assign p2_ok_s = is_single_press(p2_btn_i);

  // Select a press and compute the next priority holder.
  always_comb begin
    valid_o = 1'b0;
    id_o    = 1'b0;
    code_o  = 3'd0;
    if (p1_ok_s && p2_ok_s) begin
      valid_o = 1'b1;
      id_o    = rr_q;
      code_o  = rr_q ? onehot_to_code(p2_btn_i) : onehot_to_code(p1_btn_i);
    end else if (p1_ok_s) begin
      valid_o = 1'b1;
      id_o    = 1'b0;
      code_o  = onehot_to_code(p1_btn_i);
    end else if (p2_ok_s) begin
      valid_o = 1'b1;
      id_o    = 1'b1;
      code_o  = onehot_to_code(p2_btn_i);
    end else begin
      valid_o = 1'b0;
    end

    rr_d = rr_q;
    if (en_i && valid_o) begin
      rr_d = ~id_o;
    end else begin
      rr_d = rr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/bomb_phase_sequencer.sv
// bomb_phase_sequencer: two-player "defuse the bomb" game controller.
//   clk, rst    : clock, async active-high reset
//   tick        : one-cycle 1 Hz strobe
//   start       : arm (from IDLE) / return to IDLE (from DEFUSED/EXPLODED)
//   p1_btn      : player-1 press pulses {right,left,up,down,a,b}
//   p2_btn      : player-2 press pulses, same order
//   state       : game state (see bomb_pkg::state_e)
//   phase, step : progress through the SOLUTION table
//   seconds     : countdown remaining
//   strikes     : wrong presses so far
//   grant_valid : one-cycle pulse per accepted press
//   grant_id    : player of the last accepted press (held between grants)
// All outputs are registered and change one cycle after their cause.
module bomb_phase_sequencer
  import bomb_pkg::*;
#(
  parameter int unsigned NUM_PHASES    = 4,
  parameter int unsigned STEPS         = 4,
  parameter int unsigned START_SECONDS = 60,
  parameter int unsigned MAX_STRIKES   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic [5:0] p1_btn,
  input  logic [5:0] p2_btn,
  output logic [1:0] state,
  output logic [2:0] phase,
  output logic [2:0] step,
  output logic [6:0] seconds,
  output logic [1:0] strikes,
  output logic       grant_valid,
  output logic       grant_id
);

  localparam logic [2:0] LAST_PHASE = 3'(NUM_PHASES - 1);
  localparam logic [2:0] LAST_STEP  = 3'(STEPS - 1);
  localparam logic [6:0] START_SEC  = 7'(START_SECONDS);
  localparam logic [1:0] LAST_SAFE  = 2'(MAX_STRIKES - 1);

  state_e     state_q,   state_d;
  logic [2:0] phase_q,   phase_d;
  logic [2:0] step_q,    step_d;
  logic [6:0] seconds_q, seconds_d;
  logic [1:0] strikes_q, strikes_d;
  logic       gvalid_q,  gvalid_d;
  logic       gid_q,     gid_d;

  logic       armed_s;
  logic       arb_valid_s;
  logic       arb_id_s;
  btn_code_t  arb_code_s;
  logic       boom_s;
  logic       win_s;

  assign armed_s = (state_q == ST_ARMED);

  press_arbiter u_arb (
    .clk      (clk),
    .rst      (rst),
    .en_i     (armed_s),
    .p1_btn_i (p1_btn),
    .p2_btn_i (p2_btn),
    .valid_o  (arb_valid_s),
    .id_o     (arb_id_s),
    .code_o   (arb_code_s)
  );

  // Game next-state: press and tick effects are evaluated independently
  // and combined, with an explosion taking precedence over a defuse.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    step_d    = step_q;
    seconds_d = seconds_q;
    strikes_d = strikes_q;
    gvalid_d  = 1'b0;
    gid_d     = gid_q;
    boom_s    = 1'b0;
    win_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_ARMED;
          phase_d   = 3'd0;
          step_d    = 3'd0;
          seconds_d = START_SEC;
          strikes_d = 2'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ARMED: begin
        if (arb_valid_s) begin
          gvalid_d = 1'b1;
          gid_d    = arb_id_s;
          if (arb_code_s == solution_at(phase_q[1:0], step_q[1:0])) begin
            if (step_q == LAST_STEP) begin
              // Final step of final phase: leave phase/step frozen there.
              if (phase_q == LAST_PHASE) begin
                win_s = 1'b1;
              end else begin
                step_d  = 3'd0;
                phase_d = phase_q + 3'd1;
              end
            end else begin
              step_d = step_q + 3'd1;
            end
          end else begin
            strikes_d = strikes_q + 2'd1;
            step_d    = 3'd0;
            if (strikes_q == LAST_SAFE) begin
              boom_s = 1'b1;
            end else begin
              boom_s = 1'b0;
            end
          end
        end else begin
          gvalid_d = 1'b0;
        end

        if (tick) begin
          if (seconds_q == 7'd1) begin
            seconds_d = 7'd0;
            boom_s    = 1'b1;
          end else if (seconds_q != 7'd0) begin
            seconds_d = seconds_q - 7'd1;
          end else begin
            seconds_d = 7'd0;
          end
        end else begin
          seconds_d = seconds_q;
        end

        if (boom_s) begin
          state_d = ST_EXPLODED;
        end else if (win_s) begin
          state_d = ST_DEFUSED;
        end else begin
          state_d = ST_ARMED;
        end
      end

      ST_DEFUSED, ST_EXPLODED: begin
        if (start) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= 3'd0;
      step_q    <= 3'd0;
      seconds_q <= START_SEC;
      strikes_q <= 2'd0;
      gvalid_q  <= 1'b0;
      gid_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      step_q    <= step_d;
      seconds_q <= seconds_d;
      strikes_q <= strikes_d;
      gvalid_q  <= gvalid_d;
      gid_q     <= gid_d;
    end
  end

  assign state       = state_q;
  assign phase       = phase_q;
  assign step        = step_q;
  assign seconds     = seconds_q;
  assign strikes     = strikes_q;
  assign grant_valid = gvalid_q;
  assign grant_id    = gid_q;

endmodule

// File: tb/tb_bomb_phase_sequencer.sv
// Self-checking bench for bomb_phase_sequencer. Expected grants are queued
// when a press is driven and popped when grant_valid is observed.
module tb_bomb_phase_sequencer;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_DEF  = 2'd2;
  localparam logic [1:0] S_EXP  = 2'd3;

  localparam logic [2:0] TB_SOL [4][4] = '{
    '{3'd0, 3'd1, 3'd2, 3'd3},
    '{3'd5, 3'd4, 3'd3, 3'd2},
    '{3'd1, 3'd1, 3'd0, 3'd5},
    '{3'd4, 3'd2, 3'd5, 3'd0}
  };

  logic       clk;
  logic       rst;
  logic       tick;
  logic       start;
  logic [5:0] p1_btn;
  logic [5:0] p2_btn;
  logic [1:0] state;
  logic [2:0] phase;
  logic [2:0] step;
  logic [6:0] seconds;
  logic [1:0] strikes;
  logic       grant_valid;
  logic       grant_id;

  int   n_tests;
  int   n_fail;
  int   n_grants;
  logic exp_q[$];

  bomb_phase_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .start       (start),
    .p1_btn      (p1_btn),
    .p2_btn      (p2_btn),
    .state       (state),
    .phase       (phase),
    .step        (step),
    .seconds     (seconds),
    .strikes     (strikes),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp_v);
    end
  endtask

  function automatic logic [5:0] oh(input logic [2:0] c);
    logic [5:0] v;
    v = 6'd1 << c;
    return v;
  endfunction

  function automatic logic [2:0] wrong(input logic [2:0] c);
    return (c == 3'd5) ? 3'd0 : c + 3'd1;
  endfunction

  // One clock cycle of stimulus; eg/eid give the grant this cycle should produce.
  task automatic drive(input logic [5:0] a, input logic [5:0] b, input logic tk,
                       input logic st, input logic eg, input logic eid);
    logic e;
    p1_btn = a; p2_btn = b; tick = tk; start = st;
    if (eg) exp_q.push_back(eid);
    @(posedge clk); #1;
    p1_btn = 6'd0; p2_btn = 6'd0; tick = 1'b0; start = 1'b0;
    check_eq("grant_valid", 32'(grant_valid), 32'(eg));
    if (grant_valid) begin
      n_grants++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_grant", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("grant_id", 32'(grant_id), 32'(e));
      end
    end
  endtask

  task automatic expect_status(input string tag, input logic [1:0] st, input logic [2:0] ph,
                               input logic [2:0] sp, input logic [6:0] sec, input logic [1:0] stk);
    check_eq({tag, "_state"},   32'(state),   32'(st));
    check_eq({tag, "_phase"},   32'(phase),   32'(ph));
    check_eq({tag, "_step"},    32'(step),    32'(sp));
    check_eq({tag, "_seconds"}, 32'(seconds), 32'(sec));
    check_eq({tag, "_strikes"}, 32'(strikes), 32'(stk));
  endtask

  task automatic do_reset();
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic arm();
    drive(6'd0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_status("arm", S_ARM, 3'd0, 3'd0, 7'd60, 2'd0);
  endtask

  initial begin
    int g0;
    logic [2:0] e_ph, e_sp;
    n_tests = 0; n_fail = 0; n_grants = 0;
    rst = 1'b1; tick = 1'b0; start = 1'b0; p1_btn = 6'd0; p2_btn = 6'd0;
    @(posedge clk); #1;
    expect_status("reset", S_IDLE, 3'd0, 3'd0, 7'd60, 2'd0);
    check_eq("reset_gvalid", 32'(grant_valid), 32'd0);
    check_eq("reset_gid", 32'(grant_id), 32'd0);
    rst = 1'b0;

    // Full defuse by player 1.
    drive(oh(3'd0), 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_status("idle_press", S_IDLE, 3'd0, 3'd0, 7'd60, 2'd0);
    arm();
    g0 = n_grants;
    for (int ph = 0; ph < 4; ph++) begin
      for (int s = 0; s < 4; s++) begin
        drive(oh(TB_SOL[ph][s]), 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        if (ph == 3 && s == 3) begin
          expect_status("defuse_last", S_DEF, 3'd3, 3'd3, 7'd60, 2'd0);
        end else begin
          e_ph = (s == 3) ? 3'(ph + 1) : 3'(ph);
          e_sp = (s == 3) ? 3'd0 : 3'(s + 1);
          expect_status("defuse", S_ARM, e_ph, e_sp, 7'd60, 2'd0);
        end
      end
    end
    check_eq("defuse_grants", 32'(n_grants - g0), 32'd16);
    drive(oh(3'd1), 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_status("defuse_frozen", S_DEF, 3'd3, 3'd3, 7'd60, 2'd0);

    // Three wrong presses explode the bomb.
    do_reset();
    arm();
    drive(oh(TB_SOL[0][0]), 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_status("strike_pre", S_ARM, 3'd0, 3'd1, 7'd60, 2'd0);
    drive(oh(wrong(TB_SOL[0][1])), 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_status("strike1", S_ARM, 3'd0, 3'd0, 7'd60, 2'd1);
    drive(oh(TB_SOL[0][0]), 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(oh(wrong(TB_SOL[0][1])), 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_status("strike2", S_ARM, 3'd0, 3'd0, 7'd60, 2'd2);
    drive(oh(wrong(TB_SOL[0][0])), 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_status("strike3", S_EXP, 3'd0, 3'd0, 7'd60, 2'd3);

    // Countdown to zero.
    do_reset();
    arm();
    for (int i = 1; i <= 60; i++) begin
      drive(6'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("tick_seconds", 32'(seconds), 32'(60 - i));
      check_eq("tick_state", 32'(state), (i == 60) ? 32'(S_EXP) : 32'(S_ARM));
    end
    drive(6'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_status("tick61", S_EXP, 3'd0, 3'd0, 7'd0, 2'd0);

    // Round-robin contention and invalid vectors.
    do_reset();
    arm();
    drive(oh(TB_SOL[0][0]), oh(3'd5), 1'b0, 1'b0, 1'b1, 1'b0);
    drive(oh(3'd5), oh(TB_SOL[0][1]), 1'b0, 1'b0, 1'b1, 1'b1);
    drive(oh(TB_SOL[0][2]), oh(3'd5), 1'b0, 1'b0, 1'b1, 1'b0);
    expect_status("rr", S_ARM, 3'd0, 3'd3, 7'd60, 2'd0);
    drive(6'd0, 6'b000011, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_status("multibit", S_ARM, 3'd0, 3'd3, 7'd60, 2'd0);
    check_eq("gid_hold", 32'(grant_id), 32'd0);
    drive(6'b110000, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_status("start_in_armed", S_ARM, 3'd0, 3'd3, 7'd60, 2'd0);

    // Final press coinciding with the last tick: explosion wins.
    do_reset();
    arm();
    for (int i = 0; i < 59; i++) drive(6'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("sec_at_1", 32'(seconds), 32'd1);
    for (int i = 0; i < 15; i++) drive(oh(TB_SOL[i / 4][i % 4]), 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_status("race_pre", S_ARM, 3'd3, 3'd3, 7'd1, 2'd0);
    drive(oh(TB_SOL[3][3]), 6'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_status("race", S_EXP, 3'd3, 3'd3, 7'd0, 2'd0);
    drive(6'd0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_status("to_idle", S_IDLE, 3'd3, 3'd3, 7'd0, 2'd0);
    drive(6'd0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_status("rearm", S_ARM, 3'd0, 3'd0, 7'd60, 2'd0);

    // Asynchronous reset mid-game with a grant just issued and a press pending.
    do_reset();
    arm();
    for (int i = 0; i < 8; i++) drive(oh(TB_SOL[i / 4][i % 4]), 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(oh(wrong(TB_SOL[2][0])), 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(oh(TB_SOL[2][0]), 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(6'd0, oh(wrong(TB_SOL[2][1])), 1'b0, 1'b0, 1'b1, 1'b1);
    expect_status("pre_rst", S_ARM, 3'd2, 3'd0, 7'd60, 2'd2);
    p1_btn = oh(TB_SOL[2][0]);
    #2;
    rst = 1'b1;
    #1;
    expect_status("async_rst", S_IDLE, 3'd0, 3'd0, 7'd60, 2'd0);
    check_eq("async_rst_gvalid", 32'(grant_valid), 32'd0);
    check_eq("async_rst_gid", 32'(grant_id), 32'd0);
    @(posedge clk); #1;
    check_eq("rst_held_gvalid", 32'(grant_valid), 32'd0);
    check_eq("rst_held_state", 32'(state), 32'(S_IDLE));
    rst = 1'b0;
    p1_btn = 6'd0;
    drive(6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_status("post_rst", S_IDLE, 3'd0, 3'd0, 7'd60, 2'd0);
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bomb_phase_sequencer.md
BOMB_PHASE_SEQUENCER -- requirements
Module: bomb_phase_sequencer

Interface
REQ-001 SHALL have parameter NUM_PHASES, default 4, meaning the number of phases to defuse.
REQ-002 SHALL have parameter STEPS, default 4, meaning the button codes per phase.
REQ-003 SHALL have parameter START_SECONDS, default 60, meaning the countdown load value.
REQ-004 SHALL have parameter MAX_STRIKES, default 3, meaning the number of wrong presses that detonates.
REQ-005 SHALL have one clock; reset is asynchronous and active-high, with ports named clk and rst.
REQ-006 clk  in  1  system clock.
REQ-007 rst  in  1  async active-high reset.
REQ-008 tick  in  1  one-cycle 1 Hz strobe from the clock divider.
REQ-009 start  in  1  one-cycle arm/clear pulse.
REQ-010 p1_btn  in  6  player-1 press pulses {right,left,up,down,a,b}.
REQ-011 p2_btn  in  6  player-2 press pulses, same order.
REQ-012 state  out  2  game state enum.
REQ-013 phase  out  3  current phase index.
REQ-014 step  out  3  current step within phase.
REQ-015 seconds  out  7  seconds remaining.
REQ-016 strikes  out  2  strike count.
REQ-017 grant_valid  out  1  pulse: a press was accepted this cycle.
REQ-018 grant_id  out  1  0 = player 1 and 1 = player 2 for the last grant.

Function
REQ-019 SHALL implement states IDLE, ARMED, DEFUSED, EXPLODED, all registered; every output SHALL update one cycle after its cause.
REQ-020 In IDLE, start SHALL go to ARMED and load seconds=START_SECONDS, phase=0, step=0, strikes=0.
REQ-021 A player press SHALL be valid only when exactly one bit of its 6-bit vector is set; zero or multi-bit vectors SHALL be ignored with no strike.
REQ-022 SHALL honour presses and tick only in ARMED; in all other states they are ignored.
REQ-023 When both players are valid in the same cycle, SHALL grant the player not granted last (round-robin); the losing press SHALL be dropped; after reset player 1 has priority.
REQ-024 A granted press equal to SOLUTION[phase][step] SHALL advance step; at step==STEPS-1 it SHALL set step=0 and phase+1; at the last step of the last phase it SHALL go to DEFUSED.
REQ-025 A granted mismatching press SHALL increment strikes and reset step to 0 while keeping phase; on reaching MAX_STRIKES it SHALL go to EXPLODED.
REQ-026 In ARMED, tick SHALL decrement seconds; tick at seconds==1 SHALL set seconds=0 and go to EXPLODED; seconds SHALL never wrap.
REQ-027 On simultaneous tick and a press in the same cycle, both effects SHALL apply; if either causes EXPLODED, EXPLODED SHALL win over DEFUSED.
REQ-028 DEFUSED and EXPLODED SHALL freeze phase, step, seconds and strikes; start SHALL return to IDLE without clearing them.
REQ-029 start during ARMED SHALL be ignored.
REQ-030 grant_valid SHALL pulse for exactly one cycle per accepted press; grant_id SHALL hold its value between grants.

Reset
REQ-031 rst SHALL asynchronously force state=IDLE, phase=0, step=0, seconds=START_SECONDS, strikes=0, grant_valid=0, grant_id=0, round-robin pointer=player 1.
REQ-032 rst asserted mid-ARMED SHALL abandon the game immediately, with no pending grant surviving.

Structure
REQ-033 Package bomb_pkg SHALL hold the state enum, the 3-bit button code typedef, the one-hot-to-code function and the SOLUTION constant table [NUM_PHASES][STEPS].
REQ-034 The two-player validity check and round-robin SHALL live in sub-module press_arbiter, which outputs valid, id and code.
REQ-035 SOLUTION SHALL be a constant table and SHALL NOT be a port.

Verification
REQ-036 rst, then start, then 4x4 correct presses from p1 -> DEFUSED; phase=3, step=3 frozen; 16 grant_valid pulses.
REQ-037 Armed, 3 wrong presses -> strikes 1, 2, 3 with step=0 after each; EXPLODED on the 3rd.
REQ-038 Armed, 60 ticks with no presses -> seconds 59..0; EXPLODED on the 60th tick; a 61st tick leaves seconds=0.
REQ-039 Both players press valid codes on 3 consecutive cycles -> grant_id 0, 1, 0; exactly one grant per cycle; p2_btn=6'b000011 -> no grant, no strike.
REQ-040 Final correct press coincides with tick at seconds==1 -> EXPLODED, seconds=0; a following start goes to IDLE and a further start re-arms with seconds=60.
REQ-041 rst pulsed mid-phase-2 at strikes=2 -> all outputs at reset values in the same cycle, independent of clk.
